// File: rtl/dram_cycle_ctrl.sv
// DRAM cycle sequencer for the ADAM memory board: turns buffered Z80 strobes
// into RAS/MUX/CAS, hands the bus to a DMA master via BUSRQ/BUSAK, and slips
// in RAS-only refreshes while the Z80 is off the bus.
// All DRAM strobes are registered copies of the state decode, so each strobe
// appears one B_PHI edge after the state that calls for it.
module dram_cycle_ctrl #(
    parameter int PRECHG_CYC = 1,
    parameter int REF_INT    = 64,
    parameter int REF_HOLD   = 2
) (
    input  logic       B_PHI,
    input  logic       RST_N,
    input  logic       BMREQ_N,
    input  logic       BRD_N,
    input  logic       N_BWR,
    input  logic       BRFSH_N,
    input  logic       BA15,
    input  logic       DMA_N,
    input  logic       BUSAK_N,
    output logic       BUSRQ_N,
    output logic       DMAGNT_N,
    output logic       RAS_N,
    output logic       MUX,
    output logic       CAS1_N,
    output logic       CAS2_N,
    output logic [6:0] RFADDR,
    output logic       RFADDR_EN,
    output logic       WAIT_OUT_N
);

    localparam int TW = 4;
    localparam int CW = $clog2(REF_INT) + 1;

    typedef enum logic [2:0] {IDLE, ROW, COL, CAS, REF, IREF, PRE} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [CW-1:0]   ref_cnt;
    logic            ref_due;
    logic            bank;
    logic            prot_err;
    logic            granted;
    logic            ras_d, mux_d, cas1_d, cas2_d, rfen_d;

    assign granted = ~DMAGNT_N;

    // Next-state decode and per-state strobe levels (registered below).
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        ras_d     = 1'b1;
        mux_d     = 1'b0;
        cas1_d    = 1'b1;
        cas2_d    = 1'b1;
        rfen_d    = 1'b0;
        case (state)
            IDLE: begin
                if (ref_due && granted) begin
                    state_nxt = IREF;
                    tmr_nxt   = TW'(REF_HOLD - 1);
                end else if (!BMREQ_N && !BRFSH_N) begin
                    state_nxt = REF;
                end else if (!BMREQ_N && (!BRD_N || !N_BWR)) begin
                    state_nxt = ROW;
                end
            end
            ROW: begin
                ras_d     = 1'b0;
                state_nxt = COL;
            end
            COL: begin
                ras_d     = 1'b0;
                mux_d     = 1'b1;
                state_nxt = CAS;
            end
            CAS: begin
                ras_d  = 1'b0;
                mux_d  = 1'b1;
                cas1_d = bank;
                cas2_d = ~bank;
                if (BMREQ_N) begin
                    state_nxt = PRE;
                    tmr_nxt   = TW'(PRECHG_CYC - 1);
                end
            end
            REF: begin
                ras_d = 1'b0;
                if (BMREQ_N) begin
                    state_nxt = PRE;
                    tmr_nxt   = TW'(PRECHG_CYC - 1);
                end
            end
            IREF: begin
                ras_d  = 1'b0;
                rfen_d = 1'b1;
                if (tmr == '0) begin
                    state_nxt = PRE;
                    tmr_nxt   = TW'(PRECHG_CYC - 1);
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            PRE: begin
                if (tmr == '0) state_nxt = IDLE;
                else           tmr_nxt   = tmr - TW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, dwell timer, and CAS bank latched as CAS is entered.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            tmr   <= '0;
            bank  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (state == COL) bank <= BA15;
        end
    end

    // Registered DRAM strobes; reset drops them at once, aborting any cycle.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            RAS_N     <= 1'b1;
            MUX       <= 1'b0;
            CAS1_N    <= 1'b1;
            CAS2_N    <= 1'b1;
            RFADDR_EN <= 1'b0;
        end else begin
            RAS_N     <= ras_d;
            MUX       <= mux_d;
            CAS1_N    <= cas1_d;
            CAS2_N    <= cas2_d;
            RFADDR_EN <= rfen_d;
        end
    end

    // DMA bus handshake; a BUSAK release mid-grant kills the grant until DMA_N lifts.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            BUSRQ_N  <= 1'b1;
            DMAGNT_N <= 1'b1;
            prot_err <= 1'b0;
        end else if (DMA_N) begin
            BUSRQ_N  <= 1'b1;
            DMAGNT_N <= 1'b1;
            prot_err <= 1'b0;
        end else begin
            if (DMAGNT_N && !prot_err) BUSRQ_N <= 1'b0;
            if (!DMAGNT_N && BUSAK_N) begin
                DMAGNT_N <= 1'b1;
                prot_err <= 1'b1;
            end else if (!BUSRQ_N && !BUSAK_N && !prot_err) begin
                DMAGNT_N <= 1'b0;
            end
        end
    end

    // Refresh interval timer; the row address advances as RFADDR_EN drops,
    // so the address is stable for the whole time it is driven.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt <= '0;
            ref_due <= 1'b0;
            RFADDR  <= '0;
        end else begin
            if (DMAGNT_N || (state == IDLE && state_nxt == IREF)) begin
                ref_cnt <= '0;
                ref_due <= 1'b0;
            end else if (!ref_due) begin
                ref_cnt <= ref_cnt + CW'(1);
                if (ref_cnt == CW'(REF_INT - 2)) ref_due <= 1'b1;
            end
            if (state == PRE && RFADDR_EN) RFADDR <= RFADDR + 7'd1;
        end
    end

    // Stall a DMA access that collides with a pending/active refresh until IDLE.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N)
            WAIT_OUT_N <= 1'b1;
        else if (granted && !BMREQ_N && (ref_due || state == IREF))
            WAIT_OUT_N <= 1'b0;
        else if (state == IDLE)
            WAIT_OUT_N <= 1'b1;
    end

endmodule

// File: tb/tb_dram_cycle_ctrl.sv
// Directed bench for dram_cycle_ctrl: read/write/refresh timing, async reset,
// DMA handshake, hidden refresh interval and wrap, refresh/DMA contention.
module tb_dram_cycle_ctrl;

    logic       B_PHI, RST_N;
    logic       BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA15, DMA_N, BUSAK_N;
    logic       BUSRQ_N, DMAGNT_N, RAS_N, MUX, CAS1_N, CAS2_N, RFADDR_EN, WAIT_OUT_N;
    logic [6:0] RFADDR;

    int vectors = 0;
    int miscompares = 0;

    dram_cycle_ctrl #(.PRECHG_CYC(1), .REF_INT(64), .REF_HOLD(2)) dut (
        .B_PHI(B_PHI), .RST_N(RST_N), .BMREQ_N(BMREQ_N), .BRD_N(BRD_N),
        .N_BWR(N_BWR), .BRFSH_N(BRFSH_N), .BA15(BA15), .DMA_N(DMA_N),
        .BUSAK_N(BUSAK_N), .BUSRQ_N(BUSRQ_N), .DMAGNT_N(DMAGNT_N), .RAS_N(RAS_N),
        .MUX(MUX), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N), .RFADDR(RFADDR),
        .RFADDR_EN(RFADDR_EN), .WAIT_OUT_N(WAIT_OUT_N)
    );

    initial B_PHI = 1'b0;
    always #5 B_PHI = ~B_PHI;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge B_PHI);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; BMREQ_N = 1'b1; BRD_N = 1'b1; N_BWR = 1'b1; BRFSH_N = 1'b1;
        BA15 = 1'b0; DMA_N = 1'b1; BUSAK_N = 1'b1;
        #12;
        chk("rst_ras",   8'(RAS_N), 8'h1);
        chk("rst_cas1",  8'(CAS1_N), 8'h1);
        chk("rst_cas2",  8'(CAS2_N), 8'h1);
        chk("rst_mux",   8'(MUX), 8'h0);
        chk("rst_busrq", 8'(BUSRQ_N), 8'h1);
        chk("rst_gnt",   8'(DMAGNT_N), 8'h1);
        chk("rst_wait",  8'(WAIT_OUT_N), 8'h1);
        chk("rst_rfa",   8'(RFADDR), 8'h00);
        chk("rst_rfen",  8'(RFADDR_EN), 8'h0);
        RST_N = 1'b1;

        // Read, upper bank: RAS +1, MUX +2, CAS2 +3 after the sampling edge.
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA15 = 1'b1;
        tick(); chk("rd_e0_ras", 8'(RAS_N), 8'h1);
        tick(); chk("rd_e1_ras", 8'(RAS_N), 8'h0); chk("rd_e1_mux", 8'(MUX), 8'h0);
        tick(); chk("rd_e2_mux", 8'(MUX), 8'h1);   chk("rd_e2_cas2", 8'(CAS2_N), 8'h1);
        tick(); chk("rd_e3_cas2", 8'(CAS2_N), 8'h0); chk("rd_e3_cas1", 8'(CAS1_N), 8'h1);
        BMREQ_N = 1'b1; BRD_N = 1'b1; BA15 = 1'b0;
        tick(); chk("rd_e4_cas2", 8'(CAS2_N), 8'h0);
        tick(); chk("rd_pre_ras", 8'(RAS_N), 8'h1); chk("rd_pre_cas2", 8'(CAS2_N), 8'h1);
        chk("rd_pre_mux", 8'(MUX), 8'h0);

        // Write, lower bank, issued straight after the single precharge cycle.
        BMREQ_N = 1'b0; N_BWR = 1'b0; BA15 = 1'b0;
        tick(); chk("wr_e0_ras", 8'(RAS_N), 8'h1);
        tick(); chk("wr_e1_ras", 8'(RAS_N), 8'h0);
        tick(); chk("wr_e2_mux", 8'(MUX), 8'h1);   chk("wr_e2_cas1", 8'(CAS1_N), 8'h1);
        tick(); chk("wr_e3_cas1", 8'(CAS1_N), 8'h0); chk("wr_e3_cas2", 8'(CAS2_N), 8'h1);
        BMREQ_N = 1'b1; N_BWR = 1'b1;
        tick();
        tick(); chk("wr_pre_ras", 8'(RAS_N), 8'h1); chk("wr_pre_cas1", 8'(CAS1_N), 8'h1);

        // Z80 refresh: RAS only.
        BMREQ_N = 1'b0; BRFSH_N = 1'b0;
        tick();
        tick(); chk("zr_ras", 8'(RAS_N), 8'h0); chk("zr_mux", 8'(MUX), 8'h0);
        chk("zr_cas1", 8'(CAS1_N), 8'h1); chk("zr_cas2", 8'(CAS2_N), 8'h1);
        tick(); chk("zr_ras2", 8'(RAS_N), 8'h0); chk("zr_cas1b", 8'(CAS1_N), 8'h1);
        BMREQ_N = 1'b1; BRFSH_N = 1'b1;
        tick();
        tick(); chk("zr_end_ras", 8'(RAS_N), 8'h1);

        // Async reset while CAS1 is active.
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA15 = 1'b0;
        repeat (4) tick();
        chk("ar_cas1_on", 8'(CAS1_N), 8'h0);
        #2; RST_N = 1'b0; #1;
        chk("ar_ras", 8'(RAS_N), 8'h1); chk("ar_cas1", 8'(CAS1_N), 8'h1);
        chk("ar_mux", 8'(MUX), 8'h0);
        BMREQ_N = 1'b1; BRD_N = 1'b1; RST_N = 1'b1;
        tick(); chk("ar_post_ras", 8'(RAS_N), 8'h1); chk("ar_post_rfa", 8'(RFADDR), 8'h00);

        // DMA handshake, then the first hidden refresh 64 cycles into the grant.
        DMA_N = 1'b0;
        tick(); chk("dma_busrq", 8'(BUSRQ_N), 8'h0); chk("dma_gnt_wait", 8'(DMAGNT_N), 8'h1);
        BUSAK_N = 1'b0;
        tick(); chk("dma_gnt", 8'(DMAGNT_N), 8'h0);
        repeat (64) tick();
        chk("ir_early_ras", 8'(RAS_N), 8'h1); chk("ir_early_en", 8'(RFADDR_EN), 8'h0);
        tick(); chk("ir_c1_ras", 8'(RAS_N), 8'h0); chk("ir_c1_en", 8'(RFADDR_EN), 8'h1);
        chk("ir_c1_rfa", 8'(RFADDR), 8'h00); chk("ir_c1_cas1", 8'(CAS1_N), 8'h1);
        tick(); chk("ir_c2_ras", 8'(RAS_N), 8'h0); chk("ir_c2_en", 8'(RFADDR_EN), 8'h1);
        tick(); chk("ir_end_ras", 8'(RAS_N), 8'h1); chk("ir_end_en", 8'(RFADDR_EN), 8'h0);
        chk("ir_end_rfa", 8'(RFADDR), 8'h01);

        // 127 more intervals reach row 127; one more wraps to 0.
        repeat (8127) tick();
        chk("wrap_127", 8'(RFADDR), 8'h7f);
        tick(); chk("wrap_0", 8'(RFADDR), 8'h00);

        // Contention: DMA read lands on the cycle the next refresh becomes due.
        repeat (60) tick();
        chk("ct_wait_idle", 8'(WAIT_OUT_N), 8'h1);
        BMREQ_N = 1'b0; BRD_N = 1'b0; BA15 = 1'b0;
        tick(); chk("ct_wait0", 8'(WAIT_OUT_N), 8'h0); chk("ct_ras_idle", 8'(RAS_N), 8'h1);
        tick(); chk("ct_iref_ras", 8'(RAS_N), 8'h0); chk("ct_iref_en", 8'(RFADDR_EN), 8'h1);
        chk("ct_wait1", 8'(WAIT_OUT_N), 8'h0);
        tick(); chk("ct_iref2_ras", 8'(RAS_N), 8'h0); chk("ct_wait2", 8'(WAIT_OUT_N), 8'h0);
        tick(); chk("ct_pre_ras", 8'(RAS_N), 8'h1); chk("ct_pre_wait", 8'(WAIT_OUT_N), 8'h0);
        chk("ct_pre_rfa", 8'(RFADDR), 8'h01);
        tick(); chk("ct_idle_wait", 8'(WAIT_OUT_N), 8'h1); chk("ct_idle_ras", 8'(RAS_N), 8'h1);
        tick(); chk("ct_acc_ras", 8'(RAS_N), 8'h0);
        tick(); chk("ct_acc_mux", 8'(MUX), 8'h1);
        tick(); chk("ct_acc_cas1", 8'(CAS1_N), 8'h0);
        BMREQ_N = 1'b1; BRD_N = 1'b1; DMA_N = 1'b1;
        tick(); chk("ct_rel_busrq", 8'(BUSRQ_N), 8'h1); chk("ct_rel_gnt", 8'(DMAGNT_N), 8'h1);
        BUSAK_N = 1'b1;

        // Protocol error: BUSAK released mid-grant.
        tick(); tick();
        DMA_N = 1'b0;
        tick(); chk("pe_busrq", 8'(BUSRQ_N), 8'h0);
        BUSAK_N = 1'b0;
        tick(); chk("pe_gnt", 8'(DMAGNT_N), 8'h0);
        BUSAK_N = 1'b1;
        tick(); chk("pe_drop_gnt", 8'(DMAGNT_N), 8'h1); chk("pe_hold_rq", 8'(BUSRQ_N), 8'h0);
        BUSAK_N = 1'b0;
        tick(); chk("pe_no_regrant", 8'(DMAGNT_N), 8'h1); chk("pe_hold_rq2", 8'(BUSRQ_N), 8'h0);
        DMA_N = 1'b1; BUSAK_N = 1'b1;
        tick(); chk("pe_rel_rq", 8'(BUSRQ_N), 8'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
